// File: rtl/fp_alu_sched_pkg.sv
// Shared definitions for the half-precision ALU scheduler: opcodes, the NaN
// returned on a watchdog abort, and the scheduler FSM states.
package ALUparams;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    DIV = 3'd3,
    CMP = 3'd4,
    MIN = 3'd5,
    MAX = 3'd6,
    CVT = 3'd7
  } alu_op_t;

  localparam logic [15:0] NaN = 16'h7E00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/fp_alu_sched_rr_pick.sv
// Round-robin picker: rotates the request vector so the search starts just
// after the last grant, then takes the lowest set bit.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_idx
);

  localparam int PW = $clog2(N_REQ);

  logic [N_REQ-1:0] rot;
  int               start_i;
  logic             found;

  always_comb begin
    start_i = (int'(ptr) == N_REQ - 1) ? 0 : int'(ptr) + 1;
    // Doubling the vector lets a plain right shift act as a rotate.
    rot     = N_REQ'({req, req} >> start_i);
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && rot[j]) begin
        found   = 1'b1;
        gnt_idx = PW'((start_i + j) % N_REQ);
        gnt     = N_REQ'(1) << ((start_i + j) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/fp_alu_sched.sv
// Shares one fp_alu among N_REQ requesters: round-robin grant, operand latch,
// single-cycle start, watchdog-guarded wait and a one-hot done pulse.
module fp_alu_sched
  import ALUparams::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [3*N_REQ-1:0]    req_op,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      done,
  output logic [15:0]           result,
  output logic                  err,
  output logic                  busy,
  output logic                  alu_sop,
  output logic [2:0]            alu_op,
  output logic [15:0]           alu_a,
  output logic [15:0]           alu_b,
  input  logic                  alu_rdy,
  input  logic [15:0]           alu_result
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);

  sched_state_t    state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [2:0]      op_q, op_d;
  logic [15:0]     a_q, a_d;
  logic [15:0]     b_q, b_d;
  logic [15:0]     result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            blank_q, blank_d;

  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]    gnt_idx;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    blank_d  = blank_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d = gnt_idx;
          ptr_d = gnt_idx;
          for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
              op_d = req_op[3*i +: 3];
              a_d  = req_a[16*i +: 16];
              b_d  = req_b[16*i +: 16];
            end
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        blank_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // The first WAIT cycle is blanked: rdy may still show the previous
        // result, and the watchdog only starts counting once rdy is trusted.
        blank_d = 1'b0;
        if (!blank_q) begin
          if (alu_rdy) begin
            result_d = alu_result;
            state_d  = RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            result_d = NaN;
            err_d    = 1'b1;
            state_d  = RESP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      RESP: begin
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= PW'(N_REQ - 1);
      win_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      blank_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      blank_q  <= blank_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign alu_sop = (state_q == ISSUE);
  assign alu_op  = op_q;
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign result  = result_q;
  assign done    = (state_q == RESP) ? (N_REQ'(1) << win_q) : '0;
  assign err     = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_fp_alu_sched.sv
// Randomized bench for fp_alu_sched: a behavioural ALU stand-in plus a
// transaction-level round-robin/latency model checked at each done.
module tb_fp_alu_sched;
  import ALUparams::*;

  localparam int N = 4;
  localparam int T = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [3*N-1:0]  req_op = '0;
  logic [16*N-1:0] req_a = '0;
  logic [16*N-1:0] req_b = '0;
  logic [N-1:0]    done;
  logic [15:0]     result;
  logic            err;
  logic            busy;
  logic            alu_sop;
  logic [2:0]      alu_op;
  logic [15:0]     alu_a;
  logic [15:0]     alu_b;
  logic            alu_rdy = 1'b0;
  logic [15:0]     alu_res = 16'hDEAD;

  fp_alu_sched #(.N_REQ(N), .TIMEOUT(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .done       (done),
    .result     (result),
    .err        (err),
    .busy       (busy),
    .alu_sop    (alu_sop),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_rdy    (alu_rdy),
    .alu_result (alu_res)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int sop_total = 0;
  int sop_mark  = 0;
  int ptr_m     = N - 1;

  logic [2:0]  pend_op [N];
  logic [15:0] pend_a  [N];
  logic [15:0] pend_b  [N];

  int          m_lat     = 1;
  bit          m_stale   = 1'b0;
  bit          m_ovr     = 1'b0;
  logic [15:0] m_ovr_val = 16'h0;
  int          alu_cnt   = 0;
  logic [15:0] alu_pend  = 16'h0;

  function automatic logic [15:0] ref_alu(logic [2:0] op, logic [15:0] a, logic [15:0] b);
    if (op == ADD && a == 16'h3C00 && b == 16'h4000) return 16'h4200;
    return (a ^ {b[7:0], b[15:8]}) + {13'd0, op};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_sop) sop_total <= sop_total + 1;
  end

  // ALU stand-in: clears rdy on sop (unless mimicking a stale rdy), raises it
  // m_lat cycles later; m_lat==0 means it never answers.
  always @(posedge clk) begin
    if (alu_sop) begin
      alu_rdy  <= m_stale;
      alu_cnt  <= m_lat;
      if (m_stale) alu_res <= 16'hBEEF;
      alu_pend <= m_ovr ? m_ovr_val : ref_alu(alu_op, alu_a, alu_b);
    end else if (alu_cnt != 0) begin
      alu_cnt <= alu_cnt - 1;
      if (alu_cnt == 1) begin
        alu_rdy <= 1'b1;
        alu_res <= alu_pend;
      end else begin
        alu_rdy <= 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic load_rand(input logic [N-1:0] set);
    for (int i = 0; i < N; i++) begin
      if (set[i]) begin
        pend_op[i] = 3'($urandom);
        pend_a[i]  = 16'($urandom);
        pend_b[i]  = 16'($urandom);
      end
    end
  endtask

  // Serve one set of simultaneous requests; each requester holds req until
  // its done. lat_fix<0 picks a random ALU latency per transaction.
  task automatic run_batch(input logic [N-1:0] set, input int lat_fix, input bit stale,
                           input bit ovr, input logic [15:0] ovr_val, input bit scramble,
                           input bit chk_abs);
    int order[$];
    int c0, csop, w, lat, n;
    bit tmo;
    logic [15:0] er;
    m_stale   = stale;
    m_ovr     = ovr;
    m_ovr_val = ovr_val;
    for (int k = 1; k <= N; k++) begin
      if (set[(ptr_m + k) % N]) order.push_back((ptr_m + k) % N);
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (set[i]) begin
        req_op[3*i +: 3]   = pend_op[i];
        req_a[16*i +: 16]  = pend_a[i];
        req_b[16*i +: 16]  = pend_b[i];
      end
    end
    req = set;
    c0  = cyc;
    foreach (order[j]) begin
      w     = order[j];
      lat   = (lat_fix >= 0) ? lat_fix : $urandom_range(1, T + 1);
      m_lat = lat;
      n = 0;
      while (!alu_sop && n < 12) begin
        @(negedge clk);
        n++;
      end
      check_eq("sop_seen", 32'(alu_sop), 32'd1);
      csop = cyc;
      if (chk_abs && j == 0) check_eq("req_to_sop", csop - c0, 1);
      check_eq("alu_op", 32'(alu_op), 32'(pend_op[w]));
      check_eq("alu_a", 32'(alu_a), 32'(pend_a[w]));
      check_eq("alu_b", 32'(alu_b), 32'(pend_b[w]));
      if (scramble) begin
        req_op[3*w +: 3]  = 3'($urandom);
        req_a[16*w +: 16] = 16'($urandom);
        req_b[16*w +: 16] = 16'($urandom);
      end
      @(negedge clk);
      n = 0;
      while (done == '0 && n < T + 6) begin
        @(negedge clk);
        n++;
      end
      tmo = (lat == 0) || (lat > T);
      er  = tmo ? 16'h7E00 : (ovr ? ovr_val : ref_alu(pend_op[w], pend_a[w], pend_b[w]));
      check_eq("done_onehot", 32'(done), 32'(1) << w);
      check_eq("result", 32'(result), 32'(er));
      check_eq("err", 32'(err), 32'(tmo));
      check_eq("sop_to_done", cyc - csop, tmo ? T + 2 : lat + 2);
      if (chk_abs && j == 0) check_eq("req_to_done", cyc - c0, 4);
      check_eq("sops_per_txn", sop_total - sop_mark, 1);
      sop_mark = sop_total;
      req[w]   = 1'b0;
      ptr_m    = w;
    end
    req = '0;
    @(negedge clk);
    check_eq("idle_after_batch", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [N-1:0] rs;
    int n;
    #1 rst = 1'b1;
    #2;
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_result", 32'(result), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_alu", {11'd0, alu_sop, alu_op, alu_a, 1'b0}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single uncontended request with the 1.0+2.0 operands.
    pend_op[0] = ADD;
    pend_a[0]  = 16'h3C00;
    pend_b[0]  = 16'h4000;
    run_batch(4'b0001, 1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1);

    load_rand(4'b1111);
    run_batch(4'b1111, -1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Put the pointer on requester 3, then show the wrap to 0 before 3.
    load_rand(4'b1000);
    run_batch(4'b1000, 2, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    load_rand(4'b1001);
    run_batch(4'b1001, 3, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    load_rand(4'b0010);
    run_batch(4'b0010, 6, 1'b1, 1'b1, 16'h4400, 1'b0, 1'b0);

    load_rand(4'b0100);
    run_batch(4'b0100, 0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    load_rand(4'b0001);
    run_batch(4'b0001, 3, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    // Last cycle where rdy still beats the watchdog, then one past it.
    load_rand(4'b0010);
    run_batch(4'b0010, T, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    load_rand(4'b0010);
    run_batch(4'b0010, T + 1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    for (int it = 0; it < 10; it++) begin
      rs = N'($urandom_range(1, (1 << N) - 1));
      load_rand(rs);
      run_batch(rs, -1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    end

    // Abort an operation in WAIT with an asynchronous reset.
    m_lat   = 0;
    m_stale = 1'b0;
    m_ovr   = 1'b0;
    load_rand(4'b0100);
    @(negedge clk);
    req_op[6 +: 3]  = pend_op[2];
    req_a[32 +: 16] = pend_a[2];
    req_b[32 +: 16] = pend_b[2];
    req = 4'b0100;
    n = 0;
    while (!alu_sop && n < 12) begin
      @(negedge clk);
      n++;
    end
    check_eq("abort_sop_seen", 32'(alu_sop), 32'd1);
    repeat (2) @(negedge clk);
    check_eq("abort_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_alu", {11'd0, alu_sop, alu_op, alu_a, 1'b0}, 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    req = '0;
    repeat (2) @(negedge clk);
    check_eq("abort_no_done", 32'(done), 32'd0);
    rst      = 1'b0;
    sop_mark = sop_total;
    ptr_m    = N - 1;
    load_rand(4'b1111);
    run_batch(4'b1111, -1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
